// File: rtl/txtsu_rr_arbiter.sv
// Round-robin arbiter that funnels several endpoint TXTSU sources into one NIC TXTSU channel.
// The granted record is captured into a holding register. The endpoint is acked immediately,
// and the record is presented to the NIC until it is acked or times out.
module txtsu_rr_arbiter #(
    parameter int unsigned g_num_ports = 2,
    parameter int unsigned g_timeout   = 1024,
    localparam int unsigned SrcW       = (g_num_ports > 1) ? $clog2(g_num_ports) : 1
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_n_i,
    input  logic [g_num_ports-1:0]    ep_valid_i,
    input  logic [5*g_num_ports-1:0]  ep_port_id_i,
    input  logic [16*g_num_ports-1:0] ep_frame_id_i,
    input  logic [32*g_num_ports-1:0] ep_ts_i,
    output logic [g_num_ports-1:0]    ep_ack_o,
    output logic                      nic_valid_o,
    output logic [4:0]                nic_port_id_o,
    output logic [15:0]               nic_frame_id_o,
    output logic [31:0]               nic_ts_o,
    output logic [SrcW-1:0]           nic_src_o,
    input  logic                      nic_ack_i,
    output logic                      drop_p1_o,
    output logic [15:0]               drop_cnt_o
);

    localparam int unsigned TmoW = (g_timeout > 1) ? $clog2(g_timeout) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(g_timeout - 1);
    localparam logic [SrcW-1:0] LastInit = SrcW'(g_num_ports - 1);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e                   state_q, state_d;
    logic [SrcW-1:0]          last_q, last_d;
    logic                     nic_valid_q, nic_valid_d;
    logic [4:0]               nic_port_id_q, nic_port_id_d;
    logic [15:0]              nic_frame_id_q, nic_frame_id_d;
    logic [31:0]              nic_ts_q, nic_ts_d;
    logic [SrcW-1:0]          nic_src_q, nic_src_d;
    logic [g_num_ports-1:0]   ep_ack_q, ep_ack_d;
    logic                     drop_p1_q, drop_p1_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;
    logic [TmoW-1:0]          tmo_cnt_q, tmo_cnt_d;

    logic [2*g_num_ports-1:0] valid_dbl;
    logic [g_num_ports-1:0]   valid_rot;
    logic                     any_valid;
    int unsigned              shamt;
    int unsigned              offset;
    int unsigned              gnt;
    logic [4:0]               cap_port_id;
    logic [15:0]              cap_frame_id;
    logic [31:0]              cap_ts;
    logic [g_num_ports-1:0]   ack_vec;

    // Pick the first valid source after the last grant, then mux out its record.
    always_comb begin
        valid_dbl    = {ep_valid_i, ep_valid_i};
        shamt        = 32'(last_q) + 32'd1;
        // Rotating right by last+1 puts the highest-priority source at bit 0.
        valid_rot    = g_num_ports'(valid_dbl >> shamt);
        any_valid    = |ep_valid_i;
        offset       = 0;
        for (int j = int'(g_num_ports) - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                offset = unsigned'(j);
            end
        end
        gnt          = (shamt + offset) % g_num_ports;
        cap_port_id  = '0;
        cap_frame_id = '0;
        cap_ts       = '0;
        ack_vec      = '0;
        for (int k = 0; k < int'(g_num_ports); k++) begin
            if (gnt == unsigned'(k)) begin
                cap_port_id  = ep_port_id_i[5*k +: 5];
                cap_frame_id = ep_frame_id_i[16*k +: 16];
                cap_ts       = ep_ts_i[32*k +: 32];
                ack_vec[k]   = 1'b1;
            end
        end
    end

    // Next-state logic: capture in IDLE, wait for NIC ack or timeout in PRESENT.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        nic_valid_d    = nic_valid_q;
        nic_port_id_d  = nic_port_id_q;
        nic_frame_id_d = nic_frame_id_q;
        nic_ts_d       = nic_ts_q;
        nic_src_d      = nic_src_q;
        ep_ack_d       = '0;
        drop_p1_d      = 1'b0;
        drop_cnt_d     = drop_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    nic_port_id_d  = cap_port_id;
                    nic_frame_id_d = cap_frame_id;
                    nic_ts_d       = cap_ts;
                    nic_src_d      = SrcW'(gnt);
                    nic_valid_d    = 1'b1;
                    ep_ack_d       = ack_vec;
                    last_d         = SrcW'(gnt);
                    tmo_cnt_d      = '0;
                    state_d        = StPresent;
                end
            end
            StPresent: begin
                // Ack takes precedence over a timeout on the same edge.
                if (nic_ack_i) begin
                    nic_valid_d = 1'b0;
                    tmo_cnt_d   = '0;
                    state_d     = StIdle;
                end else if (g_timeout != 0) begin
                    if (tmo_cnt_q == TmoLast) begin
                        nic_valid_d = 1'b0;
                        drop_p1_d   = 1'b1;
                        tmo_cnt_d   = '0;
                        state_d     = StIdle;
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset drops any record in flight.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= StIdle;
            last_q         <= LastInit;
            nic_valid_q    <= 1'b0;
            nic_port_id_q  <= '0;
            nic_frame_id_q <= '0;
            nic_ts_q       <= '0;
            nic_src_q      <= '0;
            ep_ack_q       <= '0;
            drop_p1_q      <= 1'b0;
            drop_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            nic_valid_q    <= nic_valid_d;
            nic_port_id_q  <= nic_port_id_d;
            nic_frame_id_q <= nic_frame_id_d;
            nic_ts_q       <= nic_ts_d;
            nic_src_q      <= nic_src_d;
            ep_ack_q       <= ep_ack_d;
            drop_p1_q      <= drop_p1_d;
            drop_cnt_q     <= drop_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    assign ep_ack_o       = ep_ack_q;
    assign nic_valid_o    = nic_valid_q;
    assign nic_port_id_o  = nic_port_id_q;
    assign nic_frame_id_o = nic_frame_id_q;
    assign nic_ts_o       = nic_ts_q;
    assign nic_src_o      = nic_src_q;
    assign drop_p1_o      = drop_p1_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_txtsu_rr_arbiter.sv
// Directed bench for txtsu_rr_arbiter: two ports, eight-cycle NIC timeout.
module tb_txtsu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ep_valid = '0;
    logic [9:0]  ep_port_id = '0;
    logic [31:0] ep_frame_id = '0;
    logic [63:0] ep_ts = '0;
    logic [1:0]  ep_ack;
    logic        nic_valid;
    logic [4:0]  nic_port_id;
    logic [15:0] nic_frame_id;
    logic [31:0] nic_ts;
    logic [0:0]  nic_src;
    logic        nic_ack = 1'b0;
    logic        drop_p1;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] sat_exp [3];

    txtsu_rr_arbiter #(
        .g_num_ports(2),
        .g_timeout  (8)
    ) dut (
        .clk_sys_i     (clk),
        .rst_n_i       (rst_n),
        .ep_valid_i    (ep_valid),
        .ep_port_id_i  (ep_port_id),
        .ep_frame_id_i (ep_frame_id),
        .ep_ts_i       (ep_ts),
        .ep_ack_o      (ep_ack),
        .nic_valid_o   (nic_valid),
        .nic_port_id_o (nic_port_id),
        .nic_frame_id_o(nic_frame_id),
        .nic_ts_o      (nic_ts),
        .nic_src_o     (nic_src),
        .nic_ack_i     (nic_ack),
        .drop_p1_o     (drop_p1),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ep_ack), 32'h0);
        chk({tag, "_valid"}, 32'(nic_valid), 32'h0);
        chk({tag, "_port_id"}, 32'(nic_port_id), 32'h0);
        chk({tag, "_frame_id"}, 32'(nic_frame_id), 32'h0);
        chk({tag, "_ts"}, nic_ts, 32'h0);
        chk({tag, "_src"}, 32'(nic_src), 32'h0);
        chk({tag, "_drop_p1"}, 32'(drop_p1), 32'h0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'h0);
    endtask

    initial begin
        sat_exp[0] = 16'hFFFE;
        sat_exp[1] = 16'hFFFF;
        sat_exp[2] = 16'hFFFF;

        // Reset state
        #2;
        chk_idle_outputs("rst");
        #10;
        rst_n = 1'b1;

        // 1) Single request from port 1
        ep_port_id  = {5'd7, 5'd3};
        ep_frame_id = {16'h1234, 16'hAAAA};
        ep_ts       = {32'hDEADBEEF, 32'h0BAD_F00D};
        ep_valid    = 2'b10;
        tick();
        chk("t1_ack", 32'(ep_ack), 32'h2);
        chk("t1_valid", 32'(nic_valid), 32'h1);
        chk("t1_port_id", 32'(nic_port_id), 32'd7);
        chk("t1_frame_id", 32'(nic_frame_id), 32'h1234);
        chk("t1_ts", nic_ts, 32'hDEADBEEF);
        chk("t1_src", 32'(nic_src), 32'h1);
        ep_valid = 2'b00;
        nic_ack  = 1'b1;
        tick();
        chk("t1_ack_width", 32'(ep_ack), 32'h0);
        chk("t1_valid_after_ack", 32'(nic_valid), 32'h0);
        nic_ack = 1'b0;
        tick();

        // 2) Both ports continuously valid, NIC always acking
        ep_valid = 2'b11;
        nic_ack  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_src", 32'(nic_src), 32'(i % 2));
            chk("t2_ack", 32'(ep_ack), 32'(1 << (i % 2)));
            chk("t2_frame_id", 32'(nic_frame_id), (i % 2 == 0) ? 32'hAAAA : 32'h1234);
            tick();
            chk("t2_ack_width", 32'(ep_ack), 32'h0);
            chk("t2_gap_valid", 32'(nic_valid), 32'h0);
        end
        ep_valid = 2'b00;
        nic_ack  = 1'b0;
        tick();

        // 3) NIC ack withheld: drop after eight presented cycles, then port 1 granted
        ep_valid = 2'b11;
        tick();
        chk("t3_first_src", 32'(nic_src), 32'h0);
        chk("t3_first_valid", 32'(nic_valid), 32'h1);
        ep_valid = 2'b10;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t3_hold_valid", 32'(nic_valid), 32'h1);
            chk("t3_hold_drop", 32'(drop_p1), 32'h0);
        end
        tick();
        chk("t3_drop_valid", 32'(nic_valid), 32'h0);
        chk("t3_drop_p1", 32'(drop_p1), 32'h1);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'h1);
        tick();
        chk("t3_next_src", 32'(nic_src), 32'h1);
        chk("t3_next_ack", 32'(ep_ack), 32'h2);
        chk("t3_drop_width", 32'(drop_p1), 32'h0);
        ep_valid = 2'b00;
        nic_ack  = 1'b1;
        tick();
        nic_ack = 1'b0;

        // 4) NIC ack lands on the timeout edge: no drop
        ep_valid = 2'b01;
        tick();
        chk("t4_ack", 32'(ep_ack), 32'h1);
        ep_valid = 2'b00;
        repeat (7) tick();
        chk("t4_pre_valid", 32'(nic_valid), 32'h1);
        nic_ack = 1'b1;
        tick();
        chk("t4_valid", 32'(nic_valid), 32'h0);
        chk("t4_no_drop", 32'(drop_p1), 32'h0);
        chk("t4_drop_cnt", 32'(drop_cnt), 32'h1);
        nic_ack = 1'b0;
        tick();
        chk("t4_no_late_drop", 32'(drop_p1), 32'h0);
        chk("t4_drop_cnt_hold", 32'(drop_cnt), 32'h1);

        // 5) Reset while presenting; port 0 regains priority afterwards
        ep_valid = 2'b11;
        tick();
        chk("t5_pre_src", 32'(nic_src), 32'h1);
        chk("t5_pre_valid", 32'(nic_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t5_rst");
        rst_n = 1'b1;
        tick();
        chk("t5_post_src", 32'(nic_src), 32'h0);
        chk("t5_post_ack", 32'(ep_ack), 32'h1);
        ep_valid = 2'b10;
        nic_ack  = 1'b1;
        tick();
        nic_ack  = 1'b0;
        ep_valid = 2'b00;
        tick();

        // 6) Drop counter saturates at 0xFFFF
        force dut.drop_cnt_q = 16'hFFFD;
        #1;
        release dut.drop_cnt_q;
        #1;
        chk("t6_preload", 32'(drop_cnt), 32'hFFFD);
        for (int i = 0; i < 3; i++) begin
            ep_valid = 2'b01;
            tick();
            chk("t6_grant", 32'(ep_ack), 32'h1);
            ep_valid = 2'b00;
            repeat (7) tick();
            tick();
            chk("t6_drop_p1", 32'(drop_p1), 32'h1);
            chk("t6_drop_cnt", 32'(drop_cnt), 32'(sat_exp[i]));
        end
        tick();
        chk("t6_final_cnt", 32'(drop_cnt), 32'hFFFF);
        chk("t6_final_drop", 32'(drop_p1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
